// File: rtl/kl_line_fetch.sv
// Fetches the k and l occurrence lines for one backward-extension token and
// hands the token plus both lines to the occurrence-count stage.
module kl_line_fetch #(
  parameter int ADDR_W  = 42,
  parameter int LINE_W  = 512,
  parameter int SIDE_W  = 64,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              request_valid,
  input  logic              finish_sign,
  input  logic [5:0]        status,
  input  logic [8:0]        read_num,
  input  logic [63:0]       backward_k,
  input  logic [63:0]       backward_l,
  input  logic [ADDR_W-1:0] addr_k,
  input  logic [ADDR_W-1:0] addr_l,
  input  logic [SIDE_W-1:0] sideband,
  output logic              stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_tag,
  input  logic              mem_rsp_valid,
  input  logic              mem_rsp_tag,
  input  logic [LINE_W-1:0] mem_rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LINE_W-1:0] out_line_k,
  output logic [LINE_W-1:0] out_line_l,
  output logic [63:0]       out_backward_k,
  output logic [63:0]       out_backward_l,
  output logic [5:0]        out_status,
  output logic [8:0]        out_read_num,
  output logic              out_finish,
  output logic [SIDE_W-1:0] out_sideband,
  output logic              err_timeout,
  output logic              err_spurious
);

  typedef enum logic [2:0] {IDLE, REQ_K, REQ_L, WAIT, OUT} state_t;

  localparam logic [9:0] TO_LIM = 10'(TIMEOUT);

  state_t            state;
  logic              same;
  logic              pend_k;
  logic              pend_l;
  logic [9:0]        cnt;
  logic [ADDR_W-1:0] addr_l_q;

  logic rsp_live;
  logic rsp_k;
  logic rsp_l;
  logic rsp_drop;

  assign stall = (state != IDLE);

  // Responses only land while a fetch is in flight and the tag is still owed.
  assign rsp_live = mem_rsp_valid && (state != IDLE) && (state != OUT);
  assign rsp_k    = rsp_live && !mem_rsp_tag && pend_k;
  assign rsp_l    = rsp_live && mem_rsp_tag && pend_l;
  assign rsp_drop = mem_rsp_valid && !rsp_k && !rsp_l;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      same           <= 1'b0;
      pend_k         <= 1'b0;
      pend_l         <= 1'b0;
      cnt            <= '0;
      addr_l_q       <= '0;
      mem_req_valid  <= 1'b0;
      mem_req_addr   <= '0;
      mem_req_tag    <= 1'b0;
      out_valid      <= 1'b0;
      out_line_k     <= '0;
      out_line_l     <= '0;
      out_backward_k <= '0;
      out_backward_l <= '0;
      out_status     <= '0;
      out_read_num   <= '0;
      out_finish     <= 1'b0;
      out_sideband   <= '0;
      err_timeout    <= 1'b0;
      err_spurious   <= 1'b0;
    end else begin
      if (rsp_k) begin
        out_line_k <= mem_rsp_data;
        pend_k     <= 1'b0;
        if (same) out_line_l <= mem_rsp_data;
      end
      if (rsp_l) begin
        out_line_l <= mem_rsp_data;
        pend_l     <= 1'b0;
      end
      if (rsp_drop) err_spurious <= 1'b1;

      case (state)
        IDLE: begin
          if (request_valid || finish_sign) begin
            out_backward_k <= backward_k;
            out_backward_l <= backward_l;
            out_status     <= status;
            out_read_num   <= read_num;
            out_finish     <= finish_sign;
            out_sideband   <= sideband;
            out_line_k     <= '0;
            out_line_l     <= '0;
          end
          if (request_valid) begin
            same          <= (addr_k == addr_l);
            pend_k        <= 1'b1;
            pend_l        <= (addr_k != addr_l);
            addr_l_q      <= addr_l;
            cnt           <= '0;
            mem_req_valid <= 1'b1;
            mem_req_addr  <= addr_k;
            mem_req_tag   <= 1'b0;
            state         <= REQ_K;
          end else if (finish_sign) begin
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        REQ_K: begin
          if (mem_req_ready) begin
            if (!same) begin
              mem_req_addr <= addr_l_q;
              mem_req_tag  <= 1'b1;
              state        <= REQ_L;
            end else begin
              mem_req_valid <= 1'b0;
              state         <= WAIT;
            end
          end
        end
        REQ_L: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (!pend_k && !pend_l) begin
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            // No retry on timeout: the flag is raised and the fetch keeps waiting.
            if (cnt != TO_LIM) cnt <= cnt + 10'd1;
            if (cnt == TO_LIM - 10'd1) err_timeout <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
